intra_residue_gen: RTL and testbench
====================================

# intra_residue_gen

Encoder-side intra stage that produces the residue block and chosen mode consumed by `reconst`. It evaluates the vertical, horizontal and DC predictions for one macroblock and selects the mode with minimum SAD. It then emits the saturated signed 8-bit residue (original − prediction) and the mode index. Decoder-side reconstruction computes prediction + residue, so residue and mode encodings here match that stage.

## Interface
- `MB_SIZE_L`, default 4: block rows; power of two in {2,4,8,16}.
- `MB_SIZE_W`, default 4: block columns; must equal `MB_SIZE_L`.
- Derived: N = `MB_SIZE_L*MB_SIZE_W`; SW = $clog2(N*255+1), which is 12 for 4x4.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `enable` input 1: when low, all state, counters and outputs hold.
- `in_valid` input 1: `orig`, `top`, `left`, `top_avail` and `left_avail` are valid.
- `in_ready` output 1: block can accept a macroblock; high only in IDLE.
- `orig` input 8 x N: original pixels, raster order, k = r*MB_SIZE_W + c.
- `top` input 8 x MB_SIZE_W: reconstructed row above the block.
- `left` input 8 x MB_SIZE_L: reconstructed column left of the block.
- `top_avail` input 1: `top` is usable.
- `left_avail` input 1: `left` is usable.
- `residue` output signed 8 x N: saturated residue of the chosen mode.
- `mode` output 2: 0 = vertical, 1 = horizontal, 2 = DC.
- `sad` output SW: SAD of the chosen mode.
- `done` output 1: one-cycle pulse; `residue`, `mode` and `sad` are valid from this cycle.

## Operation
- **Accept:** a handshake is `in_valid && in_ready && enable` at a rising edge. All inputs are registered at that edge; later input changes have no effect.
- **State sequence:** IDLE → DCCALC (1 cycle) → SCAN (N cycles) → DECIDE (1 cycle) → EMIT (N cycles) → DONE (1 cycle) → IDLE.
- **DCCALC:**
  - Both neighbours available: DC = (Σtop + Σleft + (L+W)/2) >> log2(L+W).
  - Top only: DC = (Σtop + W/2) >> log2 W.
  - Left only: DC = (Σleft + L/2) >> log2 L.
  - Neither: DC = 128.
- **SCAN:** pixel counter k runs 0..N−1, one pixel per cycle. Three SW-bit accumulators add |orig[k] − pred_m[k]|:
  - Vertical: pred = top[c].
  - Horizontal: pred = left[r].
  - DC: pred = DC.
  - Accumulators clear on accept. They cannot overflow at width SW.
- **DECIDE:** candidate set is vertical only if `top_avail`, horizontal only if `left_avail`, DC always. Pick the minimum SAD; on a tie, the lower mode index wins. Register `mode` and `sad`.
- **EMIT:** one pixel per cycle, residue[k] = sat8(orig[k] − pred_mode[k]).
  - The difference is computed as a 9-bit signed value.
  - sat8 clamps to [−128, 127].
- **DONE:** pulse `done`, return to IDLE, raise `in_ready`.
- **Output persistence:** `residue`, `mode` and `sad` update only during DECIDE/EMIT and hold until the next accept's DECIDE/EMIT.
- **Enable low:** freezes the state machine, the counter and the accumulators. `done` stays as it was only if already in DONE; the pulse completes when `enable` returns.
- **Reset, at any state including mid-SCAN or mid-EMIT:**
  - State goes to IDLE; the counter and accumulators clear.
  - `in_ready` = 1, `done` = 0, `mode` = 0, `sad` = 0, all `residue` = 0.
  - A partially processed block is dropped; there is no `done` for it.
- **`in_valid` outside IDLE:** ignored; there is no queuing.

## Timing
- Accept edge = cycle 0. DCCALC occupies cycle 1, SCAN cycles 2..N+1, DECIDE cycle N+2, EMIT cycles N+3..2N+2.
- `done` is high during cycle 2N+3, which is cycle 35 for 4x4. `in_ready` rises in the following cycle.
- Throughput: one block per 2N+4 cycles. Each stalled `enable` cycle adds exactly one cycle.
- `in_ready` is low from cycle 1 through the DONE cycle inclusive.
- After reset deasserts, `in_ready` = 1 and `done` = 0 in the first cycle.

## Test plan
- **Flat block:** orig all 100, top/left all 100, both available → all SADs 0, `mode` = 0 (tie-break), `sad` = 0, residues all 0, `done` exactly 35 cycles after accept.
- **Vertical stripes:** top = {10,20,30,40}, every row = {10,20,30,40}, left all 50, both available → `mode` = 0, `sad` = 0, residues 0.
- **Horizontal rows:** left = {10,20,30,40}, row r filled with left[r], `top_avail` = 0 with top garbage {255,...} → `mode` = 1, `sad` = 0; the vertical candidate is never selected.
- **No neighbours:** orig all 200 → DC = 128, `mode` = 2, residues all 72, `sad` = 1152. Second run with orig all 0 → residues all −128, `sad` = 2048.
- **Saturation:** top/left all 0, both available, orig all 255 → every SAD is 4080, `mode` = 0, residues all 127.
- **Control:** assert `reset` at cycle 8 → no `done`, outputs zeroed, `in_ready` = 1 the next cycle. Repeat the flat case with `enable` low for 5 cycles mid-SCAN → `done` at cycle 40 with identical results. `in_valid` held high continuously → blocks accepted only when `in_ready` is high.

Source files
------------

// File: rtl/intra_residue_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : intra_residue_gen_if
// Description : Macroblock request/response bundle for the intra residue
//               generator: neighbour pixels and original block in, residue,
//               chosen mode and its SAD out.
// Revision    : 1.0 - initial release
// ============================================================================
interface intra_residue_gen_if #(
    parameter int MB_SIZE_L = 4,
    parameter int MB_SIZE_W = 4
);
    localparam int c_N  = MB_SIZE_L * MB_SIZE_W;
    localparam int c_SW = $clog2(c_N * 255 + 1);

    logic                 enable;
    logic                 in_valid;
    logic                 in_ready;
    logic [7:0]           orig [c_N];
    logic [7:0]           top  [MB_SIZE_W];
    logic [7:0]           left [MB_SIZE_L];
    logic                 top_avail;
    logic                 left_avail;
    logic signed [7:0]    residue [c_N];
    logic [1:0]           mode;
    logic [c_SW-1:0]      sad;
    logic                 done;

    // Producer of macroblocks (upstream stage or bench)
    modport master (
        output enable, in_valid, orig, top, left, top_avail, left_avail,
        input  in_ready, residue, mode, sad, done
    );

    // The residue generator itself
    modport slave (
        input  enable, in_valid, orig, top, left, top_avail, left_avail,
        output in_ready, residue, mode, sad, done
    );
endinterface
`default_nettype wire

// File: rtl/intra_residue_gen.sv
`default_nettype none
// ============================================================================
// Module      : intra_residue_gen
// Description : Encoder-side intra stage. Evaluates vertical, horizontal and
//               DC predictions for one macroblock, picks the minimum-SAD mode
//               (lower index wins ties) and emits the saturated signed 8-bit
//               residue one pixel per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module intra_residue_gen #(
    parameter int MB_SIZE_L = 4,
    parameter int MB_SIZE_W = 4
) (
    input logic                  clk,
    input logic                  reset,
    intra_residue_gen_if.slave   bus
);
    localparam int c_N       = MB_SIZE_L * MB_SIZE_W;
    localparam int c_SW      = $clog2(c_N * 255 + 1);
    localparam int c_CW      = $clog2(c_N);
    localparam int c_LW      = $clog2(MB_SIZE_W);
    localparam int c_RW      = $clog2(MB_SIZE_L);
    localparam int c_SH_BOTH = $clog2(MB_SIZE_L + MB_SIZE_W);
    localparam int c_SH_TOP  = $clog2(MB_SIZE_W);
    localparam int c_SH_LEFT = $clog2(MB_SIZE_L);
    localparam logic [c_SW:0]   c_RND_BOTH = (c_SW+1)'((MB_SIZE_L + MB_SIZE_W) / 2);
    localparam logic [c_SW:0]   c_RND_TOP  = (c_SW+1)'(MB_SIZE_W / 2);
    localparam logic [c_SW:0]   c_RND_LEFT = (c_SW+1)'(MB_SIZE_L / 2);
    localparam logic [c_SW:0]   c_DC_NONE  = (c_SW+1)'(128);
    localparam logic [c_CW-1:0] c_LAST     = c_CW'(c_N - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DCCALC = 3'd1,
        S_SCAN   = 3'd2,
        S_DECIDE = 3'd3,
        S_EMIT   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_accept;
    logic                w_last;

    // Captured macroblock
    logic [7:0]          r_orig [c_N];
    logic [7:0]          r_top  [MB_SIZE_W];
    logic [7:0]          r_left [MB_SIZE_L];
    logic                r_top_av;
    logic                r_left_av;

    logic [7:0]          r_dc;
    logic [c_CW-1:0]     r_cnt;
    logic [c_SW-1:0]     r_acc_v;
    logic [c_SW-1:0]     r_acc_h;
    logic [c_SW-1:0]     r_acc_d;
    logic [1:0]          r_mode;
    logic [c_SW-1:0]     r_sad;
    logic signed [7:0]   r_residue [c_N];

    logic [c_SW:0]       w_sum_t;
    logic [c_SW:0]       w_sum_l;
    logic [c_SW:0]       w_dc_wide;
    logic [c_RW-1:0]     w_row;
    logic [c_LW-1:0]     w_col;
    logic [7:0]          w_pix;
    logic [7:0]          w_pred_v;
    logic [7:0]          w_pred_h;
    logic [7:0]          w_pred_sel;
    logic [1:0]          w_best_mode;
    logic [c_SW-1:0]     w_best_sad;

    function automatic logic [7:0] f_absdiff(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic signed [7:0] f_sat8(input logic [7:0] a, input logic [7:0] b);
        logic signed [8:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        if (d > 9'sd127)
            return 8'sh7F;
        else if (d < -9'sd128)
            return 8'sh80;
        else
            return d[7:0];
    endfunction

    // Pixel position of the counter; block sides are powers of two so row/col are bit fields
    assign w_row    = r_cnt[c_CW-1 -: c_RW];
    assign w_col    = r_cnt[c_LW-1:0];
    assign w_pix    = r_orig[r_cnt];
    assign w_pred_v = r_top[w_col];
    assign w_pred_h = r_left[w_row];
    assign w_last   = (r_cnt == c_LAST);

    // Phase sequencer state register; enable low freezes it
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else if (bus.enable)
            r_state <= w_state_nxt;
    end

    // Next-state decode and accept strobe
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_state_nxt = S_DCCALC;
                    w_accept    = bus.enable;
                end
            end
            S_DCCALC: w_state_nxt = S_SCAN;
            S_SCAN:   if (w_last) w_state_nxt = S_DECIDE;
            S_DECIDE: w_state_nxt = S_EMIT;
            S_EMIT:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.in_ready = (r_state == S_IDLE);
    assign bus.done     = (r_state == S_DONE);

    // Input capture at the accept edge; later input changes are ignored
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int k = 0; k < c_N; k++)       r_orig[k] <= bus.orig[k];
            for (int c = 0; c < MB_SIZE_W; c++) r_top[c]  <= bus.top[c];
            for (int r = 0; r < MB_SIZE_L; r++) r_left[r] <= bus.left[r];
            r_top_av  <= bus.top_avail;
            r_left_av <= bus.left_avail;
        end
    end

    // Neighbour sums and DC predictor with round-to-nearest division
    always_comb begin
        w_sum_t = '0;
        w_sum_l = '0;
        for (int c = 0; c < MB_SIZE_W; c++) w_sum_t = w_sum_t + (c_SW+1)'(r_top[c]);
        for (int r = 0; r < MB_SIZE_L; r++) w_sum_l = w_sum_l + (c_SW+1)'(r_left[r]);
        if (r_top_av && r_left_av)
            w_dc_wide = (w_sum_t + w_sum_l + c_RND_BOTH) >> c_SH_BOTH;
        else if (r_top_av)
            w_dc_wide = (w_sum_t + c_RND_TOP) >> c_SH_TOP;
        else if (r_left_av)
            w_dc_wide = (w_sum_l + c_RND_LEFT) >> c_SH_LEFT;
        else
            w_dc_wide = c_DC_NONE;
    end

    // Mode decision: DC always eligible; a lower index wins on equal SAD
    always_comb begin
        w_best_mode = 2'd2;
        w_best_sad  = r_acc_d;
        if (r_left_av && (r_acc_h <= w_best_sad)) begin
            w_best_mode = 2'd1;
            w_best_sad  = r_acc_h;
        end
        if (r_top_av && (r_acc_v <= w_best_sad)) begin
            w_best_mode = 2'd0;
            w_best_sad  = r_acc_v;
        end
    end

    // Prediction of the chosen mode for the pixel being emitted
    always_comb begin
        case (r_mode)
            2'd0:    w_pred_sel = w_pred_v;
            2'd1:    w_pred_sel = w_pred_h;
            default: w_pred_sel = r_dc;
        endcase
    end

    // Datapath: DC latch, SAD accumulation, decision and residue emission
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dc    <= '0;
            r_cnt   <= '0;
            r_acc_v <= '0;
            r_acc_h <= '0;
            r_acc_d <= '0;
            r_mode  <= '0;
            r_sad   <= '0;
            for (int k = 0; k < c_N; k++) r_residue[k] <= '0;
        end else if (bus.enable) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_cnt   <= '0;
                        r_acc_v <= '0;
                        r_acc_h <= '0;
                        r_acc_d <= '0;
                    end
                end
                S_DCCALC: r_dc <= w_dc_wide[7:0];
                S_SCAN: begin
                    r_acc_v <= r_acc_v + c_SW'(f_absdiff(w_pix, w_pred_v));
                    r_acc_h <= r_acc_h + c_SW'(f_absdiff(w_pix, w_pred_h));
                    r_acc_d <= r_acc_d + c_SW'(f_absdiff(w_pix, r_dc));
                    r_cnt   <= r_cnt + c_CW'(1);
                end
                S_DECIDE: begin
                    r_mode <= w_best_mode;
                    r_sad  <= w_best_sad;
                end
                S_EMIT: begin
                    r_residue[r_cnt] <= f_sat8(w_pix, w_pred_sel);
                    r_cnt            <= r_cnt + c_CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.mode = r_mode;
    assign bus.sad  = r_sad;

    for (genvar k = 0; k < c_N; k++) begin : g_res
        assign bus.residue[k] = r_residue[k];
    end
endmodule
`default_nettype wire

// File: tb/tb_intra_residue_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_intra_residue_gen
// Description : Scoreboard bench for intra_residue_gen: directed and random
//               macroblocks, expected results from an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_intra_residue_gen;
    localparam int L  = 4;
    localparam int W  = 4;
    localparam int N  = L * W;
    localparam int SW = $clog2(N * 255 + 1);

    typedef struct packed {
        logic [1:0]         mode;
        logic [SW-1:0]      sad;
        logic [N-1:0][7:0]  res;
        logic [31:0]        done_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] cyc = '0;
    int          errors = 0;
    int          checks = 0;
    exp_t        exp_q[$];

    logic [7:0]  s_orig [N];
    logic [7:0]  s_top  [W];
    logic [7:0]  s_left [L];
    logic        s_ta;
    logic        s_la;

    always #5 clk = ~clk;

    // Posedge count; read at negedges or #1 after an edge
    always @(posedge clk) cyc <= cyc + 1;

    intra_residue_gen_if #(.MB_SIZE_L(L), .MB_SIZE_W(W)) ifc();

    intra_residue_gen #(.MB_SIZE_L(L), .MB_SIZE_W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: build each prediction array, sum abs errors, pick best mode
    function automatic exp_t model();
        exp_t e;
        int   p [3][N];
        int   s [3];
        int   st, sl, dc, best, d;
        bit   allowed;
        st = 0;
        sl = 0;
        for (int c = 0; c < W; c++) st += int'(s_top[c]);
        for (int r = 0; r < L; r++) sl += int'(s_left[r]);
        if (s_ta && s_la)  dc = (st + sl + (L + W) / 2) / (L + W);
        else if (s_ta)     dc = (st + W / 2) / W;
        else if (s_la)     dc = (sl + L / 2) / L;
        else               dc = 128;
        for (int k = 0; k < N; k++) begin
            p[0][k] = int'(s_top[k % W]);
            p[1][k] = int'(s_left[k / W]);
            p[2][k] = dc;
        end
        best = -1;
        for (int m = 0; m < 3; m++) begin
            s[m] = 0;
            for (int k = 0; k < N; k++) begin
                d = int'(s_orig[k]) - p[m][k];
                s[m] += (d < 0) ? -d : d;
            end
            allowed = (m == 2) || (m == 0 && s_ta) || (m == 1 && s_la);
            if (allowed && (best < 0 || s[m] < s[best])) best = m;
        end
        e.mode = 2'(best);
        e.sad  = SW'(s[best]);
        for (int k = 0; k < N; k++) begin
            d = int'(s_orig[k]) - p[best][k];
            if (d > 127)  d = 127;
            if (d < -128) d = -128;
            e.res[k] = 8'(d);
        end
        e.done_cyc = '0;
        return e;
    endfunction

    task automatic apply();
        for (int k = 0; k < N; k++) ifc.orig[k] = s_orig[k];
        for (int c = 0; c < W; c++) ifc.top[c]  = s_top[c];
        for (int r = 0; r < L; r++) ifc.left[r] = s_left[r];
        ifc.top_avail  = s_ta;
        ifc.left_avail = s_la;
    endtask

    task automatic fill(input int o, input int t, input int l, input bit ta, input bit la);
        for (int k = 0; k < N; k++) s_orig[k] = 8'(o);
        for (int c = 0; c < W; c++) s_top[c]  = 8'(t);
        for (int r = 0; r < L; r++) s_left[r] = 8'(l);
        s_ta = ta;
        s_la = la;
    endtask

    // Narrow mode keeps values close together so SAD ties are frequent
    task automatic rand_block(input bit narrow);
        int base;
        base = int'($urandom_range(0, 250));
        for (int k = 0; k < N; k++) s_orig[k] = narrow ? 8'(base + int'($urandom_range(0, 3))) : 8'($urandom_range(0, 255));
        for (int c = 0; c < W; c++) s_top[c]  = narrow ? 8'(base + int'($urandom_range(0, 3))) : 8'($urandom_range(0, 255));
        for (int r = 0; r < L; r++) s_left[r] = narrow ? 8'(base + int'($urandom_range(0, 3))) : 8'($urandom_range(0, 255));
        s_ta = 1'($urandom_range(0, 1));
        s_la = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (ifc.in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (ifc.in_ready !== 1'b1) chk("in_ready_timeout", 64'(ifc.in_ready), 64'd1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("done_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    task automatic wait_until(input logic [31:0] t);
        while (cyc < t) @(negedge clk);
    endtask

    // The tb counts the period after the accept edge as cycle 1 at cyc == acc,
    // so cycle 2N+3 is observed at cyc == acc + 2N + 2.
    task automatic send(input int stall_len, input bit abort);
        logic [31:0] acc;
        exp_t        e;
        logic [N-1:0][7:0] got;
        apply();
        ifc.in_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        #1;
        acc = cyc;
        ifc.in_valid = 1'b0;
        e = model();
        e.done_cyc = acc + 32'(2 * N + 2 + stall_len);
        if (!abort) exp_q.push_back(e);
        for (int k = 0; k < N; k++) ifc.orig[k] = 8'($urandom_range(0, 255));
        ifc.top_avail  = ~s_ta;
        ifc.left_avail = ~s_la;
        if (stall_len > 0) begin
            wait_until(acc + 4);
            ifc.enable = 1'b0;
            repeat (stall_len) @(negedge clk);
            ifc.enable = 1'b1;
        end
        if (abort) begin
            wait_until(acc + 7);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            chk("abort_in_ready", 64'(ifc.in_ready), 64'd1);
            chk("abort_done", 64'(ifc.done), 64'd0);
            chk("abort_mode", 64'(ifc.mode), 64'd0);
            chk("abort_sad", 64'(ifc.sad), 64'd0);
            for (int k = 0; k < N; k++) got[k] = ifc.residue[k];
            checks++;
            if (got !== '0) begin
                errors++;
                $display("FAIL abort_residue: got %h, required all zero", got);
            end
            repeat (2 * N + 8) @(negedge clk);
        end else begin
            wait_drain();
        end
    endtask

    // in_valid held high: accepts must be spaced by one full block period
    task automatic stream(input int nblk);
        logic [31:0] acc, prev;
        exp_t        e;
        prev = '0;
        ifc.in_valid = 1'b1;
        rand_block(1'b0);
        apply();
        for (int b = 0; b < nblk; b++) begin
            wait_ready();
            @(posedge clk);
            #1;
            acc = cyc;
            e = model();
            e.done_cyc = acc + 32'(2 * N + 2);
            exp_q.push_back(e);
            if (b > 0) chk("accept_spacing", 64'(acc - prev), 64'(2 * N + 4));
            prev = acc;
            rand_block(b[0]);
            apply();
        end
        @(negedge clk);
        chk("busy_in_ready", 64'(ifc.in_ready), 64'd0);
        ifc.in_valid = 1'b0;
        wait_drain();
    endtask

    task automatic monitor();
        exp_t e;
        logic [N-1:0][7:0] got;
        forever begin
            @(negedge clk);
            if (ifc.done === 1'b1) begin
                for (int k = 0; k < N; k++) got[k] = ifc.residue[k];
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'(ifc.done), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("mode", 64'(ifc.mode), 64'(e.mode));
                    chk("sad", 64'(ifc.sad), 64'(e.sad));
                    chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
                    checks++;
                    if (got !== e.res) begin
                        errors++;
                        $display("FAIL residue: got %h, required %h", got, e.res);
                    end
                end
            end
        end
    endtask

    // Stimulus sequence
    initial begin
        logic [N-1:0][7:0] got;
        ifc.enable   = 1'b1;
        ifc.in_valid = 1'b0;
        fill(0, 0, 0, 1'b0, 1'b0);
        apply();
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 64'(ifc.in_ready), 64'd1);
        chk("reset_done", 64'(ifc.done), 64'd0);
        chk("reset_mode", 64'(ifc.mode), 64'd0);
        chk("reset_sad", 64'(ifc.sad), 64'd0);
        for (int k = 0; k < N; k++) got[k] = ifc.residue[k];
        chk("reset_residue_nonzero", 64'(got != '0), 64'd0);

        // Flat block
        fill(100, 100, 100, 1'b1, 1'b1);
        send(0, 1'b0);
        // Vertical stripes
        fill(0, 0, 50, 1'b1, 1'b1);
        for (int c = 0; c < W; c++) s_top[c] = 8'(10 * (c + 1));
        for (int k = 0; k < N; k++) s_orig[k] = 8'(10 * (k % W + 1));
        send(0, 1'b0);
        // Horizontal rows, top unusable garbage
        fill(0, 255, 0, 1'b0, 1'b1);
        for (int r = 0; r < L; r++) s_left[r] = 8'(10 * (r + 1));
        for (int k = 0; k < N; k++) s_orig[k] = s_left[k / W];
        send(0, 1'b0);
        // No neighbours
        fill(200, 7, 9, 1'b0, 1'b0);
        send(0, 1'b0);
        fill(0, 7, 9, 1'b0, 1'b0);
        send(0, 1'b0);
        // Reset mid-SCAN drops the block and zeroes outputs
        fill(50, 60, 70, 1'b1, 1'b1);
        send(0, 1'b1);
        // Saturation
        fill(255, 0, 0, 1'b1, 1'b1);
        send(0, 1'b0);
        // Flat block with a 5-cycle enable stall in SCAN
        fill(100, 100, 100, 1'b1, 1'b1);
        send(5, 1'b0);
        // Continuous in_valid
        stream(3);
        // Random blocks
        for (int i = 0; i < 24; i++) begin
            rand_block(i[0]);
            send(int'($urandom_range(0, 3)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
